// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 framing constants, default line rates and the
// receiver/transmitter state encoding used by uart_rx and uart_tx.
package uart_pkg;

   localparam int DEFAULT_BAUD_RATE = 9600;
   localparam int DEFAULT_CLK_FREQ  = 50_000_000;

   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
   localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } uart_state_t;

   // Clocks per bit; callers must keep the result in [4, 65535].
   function automatic int baud_tick(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so idle-high lines do not glitch low out of reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, qualifies the start bit at half a bit
// time, samples data/stop bits at mid-bit and emits valid/frame_err strobes.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_RATE = DEFAULT_BAUD_RATE,
   parameter int CLK_FREQ  = DEFAULT_CLK_FREQ
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int          BAUD_TICK = baud_tick(CLK_FREQ, BAUD_RATE);
   localparam logic [15:0] HALF_LAST = 16'(BAUD_TICK / 2 - 1);
   localparam logic [15:0] FULL_LAST = 16'(BAUD_TICK - 1);
   localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

   logic        rxs;
   uart_state_t state;
   logic [15:0] tick_count;
   logic [2:0]  bit_index;
   logic [7:0]  shift;

   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_rx_sync (
      .clk(clk),
      .rst(rst),
      .d  (rx),
      .q  (rxs)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tick_count <= '0;
         bit_index  <= '0;
         shift      <= '0;
         data       <= '0;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rxs) begin
                  tick_count <= '0;
                  busy       <= 1'b1;
                  state      <= START;
               end
            end
            // A start bit that is high again at mid-bit was only a glitch.
            START: begin
               if (tick_count == HALF_LAST) begin
                  tick_count <= '0;
                  bit_index  <= '0;
                  if (!rxs) begin
                     state <= DATA;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  tick_count <= tick_count + 16'd1;
               end
            end
            DATA: begin
               if (tick_count == FULL_LAST) begin
                  tick_count <= '0;
                  shift      <= {rxs, shift[7:1]};
                  if (bit_index == LAST_BIT) begin
                     state <= STOP;
                  end else begin
                     bit_index <= bit_index + 3'd1;
                  end
               end else begin
                  tick_count <= tick_count + 16'd1;
               end
            end
            STOP: begin
               if (tick_count == FULL_LAST) begin
                  tick_count <= '0;
                  if (rxs) begin
                     data  <= shift;
                     valid <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  tick_count <= tick_count + 16'd1;
               end
            end
            // Hold off until the line idles so a break is not read as frames.
            WAIT_IDLE: begin
               if (rxs) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: directed frames push
// expected strobes, a negedge monitor pops and compares each DUT strobe.
module tb_uart_rx;

   localparam int TICK = 16;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   exp_t exp_q[$];
   int   tests_run = 0;
   int   failures  = 0;

   always #5 clk = ~clk;

   uart_rx #(
      .BAUD_RATE(10),
      .CLK_FREQ (160)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .data     (data),
      .valid    (valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   // Every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (valid || frame_err) begin
         exp_t e;
         tests_run++;
         if (valid && frame_err) begin
            failures++;
            $display("[TB] FAIL strobe_overlap: valid=%b frame_err=%b, required not both high", valid, frame_err);
         end else if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_strobe: valid=%b frame_err=%b data=%h, required no strobe", valid, frame_err, data);
         end else begin
            e = exp_q.pop_front();
            if (frame_err != e.is_err || data !== e.data) begin
               failures++;
               $display("[TB] FAIL scoreboard: frame_err=%b data=%h, required frame_err=%b data=%h",
                        frame_err, data, e.is_err, e.data);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic expect_strobe(input bit is_err, input logic [7:0] b);
      exp_t e;
      e.is_err = is_err;
      e.data   = b;
      exp_q.push_back(e);
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (TICK) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_bit);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_output(name, exp_q.size(), 0);
   endtask

   initial begin
      int busy_at;
      int valid_at;
      bit seen_busy;
      logic [7:0] a5;

      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_output("reset_data", data, 8'h00);
      check_output("reset_valid", valid, 0);
      check_output("reset_frame_err", frame_err, 0);
      check_output("reset_busy", busy, 0);
      repeat (5) @(negedge clk);

      // Single frame A5 with busy and valid timing measured from the edge.
      expect_strobe(1'b0, 8'hA5);
      busy_at  = -1;
      valid_at = -1;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            int n = 0;
            while (n < 200 && valid_at < 0) begin
               @(negedge clk);
               n++;
               if (busy && busy_at < 0) busy_at = n;
               if (valid) valid_at = n;
            end
         end
      join
      check_output("busy_rise_delay", busy_at, 3);
      tests_run++;
      if (!(valid_at inside {[155:156]})) begin
         failures++;
         $display("[TB] FAIL valid_latency: got %0d clocks, required 155..156", valid_at);
      end
      drain("a5_drained");

      // Reset during data bit 3 of A5; the transmitter then aborts to idle.
      a5 = 8'hA5;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(a5[i]);
      rx = a5[3];
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rx  = 1'b1;
      check_output("midreset_busy", busy, 0);
      check_output("midreset_data", data, 8'h00);
      repeat (40) @(negedge clk);
      expect_strobe(1'b0, 8'h3C);
      send_frame(8'h3C, 1'b1);
      drain("after_reset_3c");

      // Back-to-back frames with no idle gap.
      expect_strobe(1'b0, 8'h00);
      expect_strobe(1'b0, 8'hFF);
      expect_strobe(1'b0, 8'h5A);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h5A, 1'b1);
      drain("back_to_back");

      // Glitch: 5 low clocks must not produce any strobe.
      seen_busy = 1'b0;
      rx = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (busy) seen_busy = 1'b1;
      end
      rx = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) seen_busy = 1'b1;
      end
      check_output("glitch_busy_pulsed", seen_busy, 1);
      check_output("glitch_busy_low", busy, 0);
      check_output("glitch_data_kept", data, 8'h5A);

      // Framing error followed by a 40-clock break.
      expect_strobe(1'b1, 8'h5A);
      send_frame(8'h81, 1'b0);
      repeat (40) @(negedge clk);
      check_output("break_busy_high", busy, 1);
      rx = 1'b1;
      repeat (6) @(negedge clk);
      check_output("break_busy_released", busy, 0);
      check_output("ferr_data_kept", data, 8'h5A);
      expect_strobe(1'b0, 8'h42);
      send_frame(8'h42, 1'b1);
      drain("after_ferr_42");

      // Loopback-style stream of every byte value, back to back.
      for (int b = 0; b < 256; b++) expect_strobe(1'b0, 8'(b));
      for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
      drain("stream_0_255");

      repeat (10) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the receive-side counterpart of `uart_tx` and delivers host bytes into the matrix-multiplication datapath. It synchronizes the asynchronous `rx` line, detects and qualifies start bits, samples each bit at its centre and presents each byte with a single-cycle valid strobe. Bad stop bits raise a framing-error strobe.

## Interface
- `BAUD_RATE`, 9600: line bit rate, bits/s.
- `CLK_FREQ`, 50000000: `clk` frequency, Hz.
- `BAUD_TICK`, `CLK_FREQ/BAUD_RATE`: clocks per bit (5208 at defaults); must be ≥ 4 and < 2^16.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial input; idle high.
- `data` out 8: last correctly framed byte; held until the next good frame.
- `valid` out 1: one-cycle pulse when `data` is updated.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `busy` out 1: high from start-bit detection until return to IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer; both flops are reset to 1. All logic uses the synchronized `rxs`.
- Counters:
  - `tick_count` is 16 bits and counts 0..limit−1.
  - `bit_index` is 3 bits and counts data bits 0..7.
  - `shift` is 8 bits and shifts right, with the new bit entering at bit 7.
- State machine:
  - IDLE: on `rxs`=0, clear `tick_count`, set `busy`, go to START.
  - START: at `tick_count`=`BAUD_TICK/2`−1, sample `rxs`. If 0, clear the counter and go to DATA. If 1, treat it as a glitch: go to IDLE with no pulses.
  - DATA: at `tick_count`=`BAUD_TICK`−1, shift `rxs` into `shift`. After `bit_index`=7 is sampled, go to STOP; otherwise increment `bit_index`.
  - STOP: at `tick_count`=`BAUD_TICK`−1, sample `rxs`. If 1, load `data`←`shift`, pulse `valid`, go to IDLE. If 0, pulse `frame_err`, leave `data` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs`=1, then go to IDLE. This prevents a break condition from being read as back-to-back frames.
- `valid` and `frame_err` are never high in the same cycle.
- `busy` falls in the same cycle that `valid` or `frame_err` pulses. In the error case, `busy` stays high through WAIT_IDLE.
- A new start bit is accepted in the first IDLE cycle after STOP. Back-to-back frames therefore need no extra idle time.
- `rst` asserted in any state:
  - next cycle is IDLE, with `data`=0, `valid`=0, `frame_err`=0, `busy`=0;
  - counters and `shift` are cleared and synchronizer flops are set to 1;
  - a partial frame is discarded with no pulse.

## Timing
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0.
- `busy` rises 3 clocks after the falling edge of `rx`: 2 clocks of synchronization plus 1 IDLE detect.
- Start-bit sample: `BAUD_TICK/2` clocks after detection.
- Data bit k sample: `(k+1)·BAUD_TICK` clocks after the start sample.
- Stop-bit sample: `9·BAUD_TICK` clocks after the start sample.
- `valid` or `frame_err` is registered 1 clock after the stop sample.
- Total latency from the `rx` falling edge to `valid` is ≈ 3 + `BAUD_TICK/2` + `9·BAUD_TICK` + 1 clocks.
- Sampling is at mid-bit, giving a tolerance of ±(`BAUD_TICK/2`−3) clocks of accumulated drift over the frame.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, DATA, STOP, WAIT_IDLE), 3 bits;
  - default `BAUD_RATE` and `CLK_FREQ`;
  - the `BAUD_TICK` derivation;
  - the 8N1 frame constants (data bits = 8, stop bits = 1).
  - `uart_tx` uses the same package.
- Sub-module `sync_2ff`: a 1-bit two-flop synchronizer with a reset value parameter. It is natural to factor out and reusable by other async inputs.
- Everything else (FSM, baud counter, shifter) stays in `uart_rx`.

## Test plan
Benches override `CLK_FREQ`=160 and `BAUD_RATE`=10, so `BAUD_TICK`=16.
- Reset mid-frame: drive `rx` with 8'hA5 and assert `rst` for 1 cycle at data bit 3. Required response: next cycle `busy`=0, `data`=00; no `valid` or `frame_err` for that frame; then a clean 8'h3C is received correctly.
- Single frame 8'hA5 (line 0,1,0,1,0,0,1,0,1,1):
  - `valid` high exactly 1 cycle with `data`=A5;
  - `busy` rises 3 clocks after the falling edge;
  - `valid` arrives ≈ 3+8+144+1 clocks after the edge.
- Back-to-back frames 8'h00, 8'hFF, 8'h5A with no idle gap: three `valid` pulses, `data` = 00, FF, 5A in order, `frame_err` never asserted.
- Glitch: `rx` low for 5 clocks, then high. Required response: `busy` pulses, then returns to 0 without `valid` or `frame_err`; `data` unchanged.
- Framing error: frame 8'h81 with a low stop bit, then `rx` held low for 40 clocks.
  - `frame_err` is a 1-cycle pulse; `data` keeps its prior value.
  - `busy` stays high until `rx` returns high.
  - A following 8'h42 is received correctly.
- Loopback: `uart_tx` → `uart_rx` with bytes 0..255. Required response: all 256 received in order, zero errors.
